// File: rtl/sr_pkg.sv
// sr_pkg: shared FSM encoding and default sizing for the 74HC595 serializer.
package sr_pkg;

    // Two-bit state encoding shared by the serializer FSM.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    // Default bits per transfer and system cycles per serial half-period.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIV   = 4;

endpackage

// File: rtl/phase_timer.sv
// phase_timer: counts DIV system cycles per serial phase and flags the last one.
//
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   clr   - hold the counter at 0 (used while the serializer is idle)
//   done  - high on the last cycle of each DIV-cycle phase
//
// The counter wraps to 0 on its own when done is high, so back-to-back
// phases need no explicit clear.
module phase_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic done
);

    localparam int CW = $clog2(DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign done = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = (clr || done) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shift595_tx.sv
// shift595_tx: serializes parallel words onto a 74HC595 SER/SRCLK/RCLK interface.
//
// Ports:
//   clk       - system clock
//   rst_n     - synchronous active-low reset
//   din       - parallel word to transmit (WIDTH bits)
//   din_valid - din is valid this cycle
//   din_ready - a word can be accepted this cycle (high only in IDLE)
//   ser_data  - serial data to SER
//   ser_clk   - shift clock to SRCLK (chip samples on its rising edge)
//   ser_latch - storage latch to RCLK (pulse moves the word to the outputs)
//   busy      - a transfer is in progress
//
// Each bit spends DIV cycles with ser_clk low then DIV cycles with it high,
// so ser_data only moves on falling edges and is stable for DIV cycles on
// either side of every rising edge. All outputs are registered from the
// next-state decode, keeping the external pins glitch-free while staying
// aligned with the FSM state.
module shift595_tx
    import sr_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DIV       = DEF_DIV,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_data,
    output logic             ser_clk,
    output logic             ser_latch,
    output logic             busy
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             ser_data_q, ser_data_d;
    logic             ser_clk_q, ser_clk_d;
    logic             ser_latch_q, ser_latch_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             phase_done;
    logic             shifting;

    // The timer is held clear in IDLE so the first SHIFT_LO phase is full length.
    phase_timer #(
        .DIV(DIV)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state_q == IDLE),
        .done (phase_done)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    sh_d    = din;
                    bit_d   = '0;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_done) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_done) begin
                    if (bit_q < BW'(WIDTH - 1)) begin
                        bit_d   = bit_q + BW'(1);
                        // Advance so the next bit sits where ser_data reads it.
                        sh_d    = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
                        state_d = SHIFT_LO;
                    end else begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                if (phase_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        shifting    = (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
        ser_data_d  = shifting && (MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0]);
        ser_clk_d   = (state_d == SHIFT_HI);
        ser_latch_d = (state_d == LATCH);
        ready_d     = (state_d == IDLE);
        busy_d      = !ready_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            bit_q       <= '0;
            ser_data_q  <= 1'b0;
            ser_clk_q   <= 1'b0;
            ser_latch_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bit_q       <= bit_d;
            ser_data_q  <= ser_data_d;
            ser_clk_q   <= ser_clk_d;
            ser_latch_q <= ser_latch_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign din_ready = ready_q;
    assign ser_data  = ser_data_q;
    assign ser_clk   = ser_clk_q;
    assign ser_latch = ser_latch_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shift595_tx.sv
// tb_shift595_tx: three serializer configurations checked against a behavioural 595.
//
// dut0: DIV=2 MSB first, dut1: DIV=1 LSB first, dut2: DIV=3 MSB first.
module tb_shift595_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [7:0] din [3];
    logic din_valid [3];
    logic din_ready [3];
    logic ser_data [3];
    logic ser_clk [3];
    logic ser_latch [3];
    logic busy [3];

    always #5 clk = ~clk;

    shift595_tx #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
        .ser_data(ser_data[0]), .ser_clk(ser_clk[0]), .ser_latch(ser_latch[0]), .busy(busy[0])
    );
    shift595_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
        .ser_data(ser_data[1]), .ser_clk(ser_clk[1]), .ser_latch(ser_latch[1]), .busy(busy[1])
    );
    shift595_tx #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .din(din[2]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
        .ser_data(ser_data[2]), .ser_clk(ser_clk[2]), .ser_latch(ser_latch[2]), .busy(busy[2])
    );

    int pass_n = 0;
    int tot_n = 0;

    // Behavioural 595 plus per-frame statistics, one set per DUT.
    logic [7:0] sh595 [3];
    logic [7:0] out595 [3];
    logic first_bit [3];
    logic pclk [3];
    logic pbusy [3];
    logic platch [3];
    logic pdata [3];
    int rises [3];
    int busy_n [3];
    int latch_n [3];
    int gap_n [3];
    int frames [3];
    int latches [3];
    int last_rises [3];
    int last_busy [3];
    int last_latch [3];
    int last_gap [3];
    logic [7:0] exp_q [3][$];

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s dut%0d got=%0h want=%0h at %0t", nm, i, act, exp, $time);
    endtask

    // Word the 595 storage register should hold after a frame of w.
    function automatic logic [7:0] model(int i, logic [7:0] w);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = w[7-b];
        return (i == 1) ? r : w;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ser_clk[i] && !pclk[i]) begin
                if (rises[i] == 0) first_bit[i] = ser_data[i];
                sh595[i] = {sh595[i][6:0], ser_data[i]};
                rises[i]++;
                chk("hold_at_rise", i, ser_data[i], pdata[i]);
            end
            if (ser_latch[i] && !platch[i]) begin
                out595[i] = sh595[i];
                latches[i]++;
                if (exp_q[i].size() == 0) begin
                    tot_n++;
                    $display("FAIL sb_unexpected dut%0d got=%0h want=none", i, out595[i]);
                end else begin
                    chk("sb_word", i, out595[i], exp_q[i].pop_front());
                end
            end
            if (busy[i]) busy_n[i]++;
            if (ser_latch[i]) latch_n[i]++;
            if (busy[i] && !pbusy[i]) begin
                last_gap[i] = gap_n[i];
                gap_n[i] = 0;
            end
            if (!busy[i] && pbusy[i]) begin
                last_rises[i] = rises[i];
                last_busy[i] = busy_n[i];
                last_latch[i] = latch_n[i];
                rises[i] = 0;
                busy_n[i] = 0;
                latch_n[i] = 0;
                frames[i]++;
            end
            if (!busy[i]) gap_n[i]++;
            pclk[i] = ser_clk[i];
            pbusy[i] = busy[i];
            platch[i] = ser_latch[i];
            pdata[i] = ser_data[i];
        end
    end

    task automatic send(int i, logic [7:0] w, bit push);
        int t = 0;
        while (!din_ready[i] && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!din_ready[i]) begin
            tot_n++;
            $display("FAIL ready_timeout dut%0d got=0 want=1", i);
        end
        din[i] = w;
        din_valid[i] = 1'b1;
        if (push) exp_q[i].push_back(model(i, w));
        @(negedge clk);
        din_valid[i] = 1'b0;
        chk("start_busy", i, busy[i], 1);
        chk("start_ser_clk", i, ser_clk[i], 0);
    endtask

    task automatic wait_frame(int i, int n0);
        int t = 0;
        while (frames[i] == n0 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (frames[i] == n0) begin
            tot_n++;
            $display("FAIL frame_timeout dut%0d got=%0d want=%0d", i, frames[i], n0 + 1);
        end
    endtask

    typedef struct {
        logic [7:0] w;
        bit chg;
        int rises;
        int busy_c;
        int latch_c;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int n0;
        int nl;
        int t;
        logic [7:0] prev;
        tbl[0] = '{8'hA5, 1'b0, 8, 34, 2};
        tbl[1] = '{8'h00, 1'b1, 8, 34, 2};
        tbl[2] = '{8'hFF, 1'b0, 8, 34, 2};
        tbl[3] = '{8'h5A, 1'b0, 8, 34, 2};
        tbl[4] = '{8'h80, 1'b0, 8, 34, 2};
        for (int i = 0; i < 3; i++) begin
            din[i] = 8'h00;
            din_valid[i] = 1'b0;
            sh595[i] = 8'h00;
            out595[i] = 8'h00;
            first_bit[i] = 1'b0;
            pclk[i] = 1'b0;
            pbusy[i] = 1'b0;
            platch[i] = 1'b0;
            pdata[i] = 1'b0;
            rises[i] = 0;
            busy_n[i] = 0;
            latch_n[i] = 0;
            gap_n[i] = 0;
            frames[i] = 0;
            latches[i] = 0;
            last_rises[i] = 0;
            last_busy[i] = 0;
            last_latch[i] = 0;
            last_gap[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ser_data", i, ser_data[i], 0);
            chk("rst_ser_clk", i, ser_clk[i], 0);
            chk("rst_ser_latch", i, ser_latch[i], 0);
            chk("rst_busy", i, busy[i], 0);
            chk("rst_din_ready", i, din_ready[i], 1);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single frames on dut0 (DIV=2, MSB first).
        for (int k = 0; k < 5; k++) begin
            n0 = frames[0];
            send(0, tbl[k].w, 1'b1);
            if (tbl[k].chg) begin
                din[0] = 8'hFF;
                din_valid[0] = 1'b1;
                @(negedge clk);
                din_valid[0] = 1'b0;
            end
            wait_frame(0, n0);
            chk("tbl_rises", 0, last_rises[0], tbl[k].rises);
            chk("tbl_busy", 0, last_busy[0], tbl[k].busy_c);
            chk("tbl_latch", 0, last_latch[0], tbl[k].latch_c);
            chk("tbl_out", 0, out595[0], tbl[k].chg ? 8'h00 : tbl[k].w);
        end

        // LSB first on dut1: din=01 shifts a 1 first, then seven 0s.
        n0 = frames[1];
        send(1, 8'h01, 1'b1);
        wait_frame(1, n0);
        chk("lsb_first_bit", 1, first_bit[1], 1);
        chk("lsb_out", 1, out595[1], 8'h80);
        chk("lsb_latch", 1, last_latch[1], 1);

        // Back-to-back with din_valid held high on dut1 (DIV=1).
        n0 = frames[1];
        din[1] = 8'h3C;
        din_valid[1] = 1'b1;
        exp_q[1].push_back(model(1, 8'h3C));
        @(negedge clk);
        din[1] = 8'hC3;
        exp_q[1].push_back(model(1, 8'hC3));
        wait_frame(1, n0);
        chk("b2b_busy1", 1, last_busy[1], 17);
        chk("b2b_rises1", 1, last_rises[1], 8);
        chk("b2b_idle_ready", 1, din_ready[1], 1);
        @(negedge clk);
        din_valid[1] = 1'b0;
        chk("b2b_restart", 1, busy[1], 1);
        wait_frame(1, n0 + 1);
        chk("b2b_busy2", 1, last_busy[1], 17);
        chk("b2b_gap", 1, last_gap[1], 1);
        chk("b2b_out2", 1, out595[1], model(1, 8'hC3));

        // Reset during bit 4 of F0 on dut0; dut2 sees din_valid on the reset edge.
        n0 = frames[0];
        nl = latches[0];
        prev = out595[0];
        send(0, 8'hF0, 1'b0);
        t = 0;
        while (rises[0] < 4 && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("pre_rst_ser_clk", 0, ser_clk[0], 1);
        rst_n = 1'b0;
        din[2] = 8'hAA;
        din_valid[2] = 1'b1;
        @(negedge clk);
        chk("midrst_ser_clk", 0, ser_clk[0], 0);
        chk("midrst_ser_data", 0, ser_data[0], 0);
        chk("midrst_busy", 0, busy[0], 0);
        chk("midrst_ready", 0, din_ready[0], 1);
        chk("rst_wins_busy", 2, busy[2], 0);
        rst_n = 1'b1;
        din_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_no_latch", 0, latches[0], nl);
        chk("midrst_out_kept", 0, out595[0], prev);
        chk("midrst_frames", 0, frames[0], n0 + 1);
        chk("rst_wins_idle", 2, busy[2], 0);
        n0 = frames[0];
        send(0, 8'h81, 1'b1);
        wait_frame(0, n0);
        chk("post_rst_busy", 0, last_busy[0], 34);
        chk("post_rst_out", 0, out595[0], 8'h81);

        // Random words on dut2 (DIV=3) streamed through the scoreboard.
        for (int k = 0; k < 100; k++) send(2, 8'($urandom_range(0, 255)), 1'b1);
        t = 0;
        while (exp_q[2].size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("sb_drained", i, exp_q[i].size(), 0);
        chk("rand_busy", 2, last_busy[2], 51);

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule
